// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester grant arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ_C = 4;
    localparam int unsigned ID_W      = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [ID_W-1:0] req_id_t;

    function automatic logic [NUM_REQ_C-1:0] id_to_onehot(input req_id_t id);
        return NUM_REQ_C'(1) << id;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational rotating priority encoder: round-robin search from last_ptr+1,
// or fixed priority with the highest index winning.
module rr_prio_enc
    import arb_pkg::*;
(
    input  logic [NUM_REQ_C-1:0] req,
    input  req_id_t              last_ptr,
    input  logic                 rr_mode,
    output req_id_t              win_id,
    output logic                 win_valid
);

    req_id_t              w_start;
    req_id_t              w_rr_idx;
    req_id_t              w_fix_idx;
    logic [NUM_REQ_C-1:0] w_rot;

    always_comb begin
        w_start   = last_ptr + req_id_t'(1);
        w_rot     = '0;
        w_rr_idx  = '0;
        w_fix_idx = '0;
        // Rotated view: bit 0 is the first index searched after the last owner.
        for (int i = 0; i < int'(NUM_REQ_C); i++) begin
            w_rot[i] = req[req_id_t'(w_start + req_id_t'(i))];
        end
        for (int i = int'(NUM_REQ_C) - 1; i >= 0; i--) begin
            if (w_rot[i]) w_rr_idx = req_id_t'(i);
        end
        for (int i = 0; i < int'(NUM_REQ_C); i++) begin
            if (req[i]) w_fix_idx = req_id_t'(i);
        end
        win_id    = rr_mode ? req_id_t'(w_start + w_rr_idx) : w_fix_idx;
        win_valid = |req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Grant arbiter: registers a one-hot grant that is held until the owner drops
// its request, pulses release_i, or the hold timeout expires.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_i,
    input  logic               rr_mode,
    output logic [NUM_REQ-1:0] grant,
    output req_id_t            grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    localparam int unsigned HC_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned LAST_CNT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    arb_state_t           r_state,   w_state_nxt;
    logic [NUM_REQ_C-1:0] r_grant,   w_grant_nxt;
    req_id_t              r_grant_id, w_id_nxt;
    logic                 r_grant_valid, w_valid_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic [HC_W-1:0]      r_hold_cnt, w_cnt_nxt;
    req_id_t              r_last_ptr, w_ptr_nxt;

    req_id_t              w_win_id;
    logic                 w_win_valid;
    logic                 w_req_drop;
    logic                 w_to_hit;

    rr_prio_enc u_enc (
        .req       (req),
        .last_ptr  (r_last_ptr),
        .rr_mode   (rr_mode),
        .win_id    (w_win_id),
        .win_valid (w_win_valid)
    );

    assign w_req_drop = ~req[r_grant_id];
    assign w_to_hit   = (MAX_HOLD != 0) && (r_hold_cnt == HC_W'(LAST_CNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_hold_cnt    <= '0;
            r_last_ptr    <= req_id_t'(NUM_REQ_C - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_id_nxt;
            r_grant_valid <= w_valid_nxt;
            r_timeout     <= w_timeout_nxt;
            r_hold_cnt    <= w_cnt_nxt;
            r_last_ptr    <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_id_nxt      = r_grant_id;
        w_valid_nxt   = r_grant_valid;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_hold_cnt;
        w_ptr_nxt     = r_last_ptr;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_win_valid) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = id_to_onehot(w_win_id);
                    w_id_nxt    = w_win_id;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_grant_nxt = '0;
                    w_id_nxt    = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (w_req_drop || release_i || w_to_hit) begin
                    w_state_nxt   = IDLE;
                    w_grant_nxt   = '0;
                    w_id_nxt      = '0;
                    w_valid_nxt   = 1'b0;
                    w_cnt_nxt     = '0;
                    w_ptr_nxt     = r_grant_id;
                    // Request drop and release outrank the timeout report.
                    w_timeout_nxt = w_to_hit && !w_req_drop && !release_i;
                end else if (r_hold_cnt != HC_W'(MAX_HOLD)) begin
                    w_cnt_nxt = r_hold_cnt + HC_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench: three arbiter instances (MAX_HOLD 16, 4 and 0) sharing clock and reset.
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] a_req = '0, b_req = '0, c_req = '0;
    logic       a_rel = 1'b0, b_rel = 1'b0, c_rel = 1'b0;
    logic       a_rr = 1'b0, b_rr = 1'b1, c_rr = 1'b1;
    logic [3:0] a_grant, b_grant, c_grant;
    logic [1:0] a_id, b_id, c_id;
    logic       a_valid, b_valid, c_valid;
    logic       a_to, b_to, c_to;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .release_i(a_rel), .rr_mode(a_rr),
        .grant(a_grant), .grant_id(a_id), .grant_valid(a_valid), .timeout(a_to));

    rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .release_i(b_rel), .rr_mode(b_rr),
        .grant(b_grant), .grant_id(b_id), .grant_valid(b_valid), .timeout(b_to));

    rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(c_req), .release_i(c_rel), .rr_mode(c_rr),
        .grant(c_grant), .grant_id(c_id), .grant_valid(c_valid), .timeout(c_to));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {grant, id, valid, timeout}; valid is derived from the expected grant.
    task automatic chk(input string tag, input logic [3:0] og, input logic [1:0] oi,
                       input logic ov, input logic ot,
                       input logic [3:0] eg, input logic [1:0] ei, input logic et);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {og, oi, ov, ot};
        exp = {eg, ei, |eg, et};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed grant/id/valid/to=%b_%b_%b_%b required %b_%b_%b_%b",
                   tag, obs[7:4], obs[3:2], obs[1], obs[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        #3;
        chk("reset_a", a_grant, a_id, a_valid, a_to, 4'b0000, 2'd0, 1'b0);
        chk("reset_b", b_grant, b_id, b_valid, b_to, 4'b0000, 2'd0, 1'b0);
        chk("reset_c", c_grant, c_id, c_valid, c_to, 4'b0000, 2'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fixed priority: highest index wins, then the lower requester after one idle cycle.
        a_req = 4'b1010;
        tick();
        chk("fix_win3", a_grant, a_id, a_valid, a_to, 4'b1000, 2'd3, 1'b0);
        a_req = 4'b0010;
        tick();
        chk("fix_drop_idle", a_grant, a_id, a_valid, a_to, 4'b0000, 2'd0, 1'b0);
        tick();
        chk("fix_win1", a_grant, a_id, a_valid, a_to, 4'b0010, 2'd1, 1'b0);
        a_req = 4'b0000;
        tick();
        chk("fix_end", a_grant, a_id, a_valid, a_to, 4'b0000, 2'd0, 1'b0);

        // Round robin with all requesting: 0,1,2,3,0 each for 4 cycles then a timeout idle cycle.
        b_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] eid;
            eid = 2'(k % 4);
            for (int c = 0; c < 4; c++) begin
                tick();
                chk($sformatf("rr_hold_k%0d_c%0d", k, c), b_grant, b_id, b_valid, b_to,
                    4'b0001 << eid, eid, 1'b0);
            end
            tick();
            chk($sformatf("rr_timeout_k%0d", k), b_grant, b_id, b_valid, b_to, 4'b0000, 2'd0, 1'b1);
        end
        b_req = 4'b0000;
        tick();
        chk("rr_quiet", b_grant, b_id, b_valid, b_to, 4'b0000, 2'd0, 1'b0);

        // Pointer is 0: req 0101 picks id 2; release in its second cycle ends it without timeout.
        b_req = 4'b0101;
        tick();
        chk("rel_win2", b_grant, b_id, b_valid, b_to, 4'b0100, 2'd2, 1'b0);
        tick();
        chk("rel_win2_c2", b_grant, b_id, b_valid, b_to, 4'b0100, 2'd2, 1'b0);
        b_rel = 1'b1;
        tick();
        b_rel = 1'b0;
        chk("rel_idle", b_grant, b_id, b_valid, b_to, 4'b0000, 2'd0, 1'b0);
        tick();
        chk("rel_next0", b_grant, b_id, b_valid, b_to, 4'b0001, 2'd0, 1'b0);

        // Release coinciding with the last hold cycle suppresses the timeout pulse.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("relto_hold%0d", c), b_grant, b_id, b_valid, b_to, 4'b0001, 2'd0, 1'b0);
        end
        b_rel = 1'b1;
        tick();
        b_rel = 1'b0;
        chk("relto_no_timeout", b_grant, b_id, b_valid, b_to, 4'b0000, 2'd0, 1'b0);
        tick();
        chk("relto_next2", b_grant, b_id, b_valid, b_to, 4'b0100, 2'd2, 1'b0);

        // Asynchronous reset mid-grant clears outputs immediately and restarts the pointer.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", b_grant, b_id, b_valid, b_to, 4'b0000, 2'd0, 1'b0);
        b_req = 4'b1111;
        #2;
        rst_n = 1'b1;
        tick();
        chk("rst_ptr_restart", b_grant, b_id, b_valid, b_to, 4'b0001, 2'd0, 1'b0);
        b_req = 4'b0000;
        tick();
        chk("rst_end", b_grant, b_id, b_valid, b_to, 4'b0000, 2'd0, 1'b0);
        b_req = 4'b0001;
        tick();
        chk("rst_req0001", b_grant, b_id, b_valid, b_to, 4'b0001, 2'd0, 1'b0);
        b_req = 4'b0000;

        // Timeout disabled: a single requester keeps its grant indefinitely.
        c_req = 4'b0010;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk($sformatf("nohold_c%0d", c), c_grant, c_id, c_valid, c_to, 4'b0010, 2'd1, 1'b0);
        end
        c_req = 4'b0000;
        tick();
        chk("nohold_end", c_grant, c_id, c_valid, c_to, 4'b0000, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
Sequential 4-requester arbiter that shares one downstream resource between requesters A[0..3]. It uses a rotating priority encoder to pick a winner, registers a one-hot grant plus an encoded ID and valid, and holds the grant until the owner lets go or a hold timeout fires. Selectable fixed-priority or round-robin mode. It sits in front of any shared datapath port that the encoder-style select logic drives.

Parameters:
NUM_REQ, 4, number of requesters; this block supports 4 only (ID width 2).
MAX_HOLD, 16, maximum grant length in cycles; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  request vector; bit i = requester i.
release_i  input  1  single-cycle pulse from the current owner ending its grant early.
rr_mode  input  1  1 = round-robin, 0 = fixed priority (bit 3 highest); sampled only in IDLE.
grant  output  4  registered one-hot grant; 0 when no grant is active.
grant_id  output  2  registered index of the owner; 0 when idle.
grant_valid  output  1  high while a grant is active (equals |grant).
timeout  output  1  one-cycle pulse when a grant is revoked by the hold timeout.

Behaviour:
- Reset (async on rst_n low): state=IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, hold_cnt=0, last_ptr=3. Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE: if req != 0, the winner is computed combinationally and registered. The next state is GRANT, with grant=onehot(win), grant_id=win, grant_valid=1 and hold_cnt=0. Latency is 1 clock from req sampled to grant visible. If req == 0, stay in IDLE with outputs 0.
- Fixed mode winner: the highest set index wins (1xxx -> 3, 01xx -> 2, 001x -> 1, 0001 -> 0).
- Round-robin winner: search indices last_ptr+1, last_ptr+2, ... modulo 4; the first set bit wins. After reset the search starts at index 0.
- GRANT: hold_cnt increments each cycle, saturating at MAX_HOLD. The grant ends at the clock edge where any of these holds:
  (a) req[grant_id]==0;
  (b) release_i==1;
  (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, so the grant lasts exactly MAX_HOLD cycles.
- On grant end: next state=IDLE, all grant outputs go to 0, and last_ptr<=grant_id. There is always exactly one idle cycle between consecutive grants, with no back-to-back handover.
- timeout=1 for one cycle, coincident with the first IDLE cycle, only when (c) caused the end and neither (a) nor (b) was true in the same cycle. Release and request-drop take precedence over timeout.
- Requests other than the owner's are ignored during GRANT.
- rr_mode changes during GRANT take effect at the next IDLE arbitration.
- last_ptr updates in both modes; it is only used in round-robin mode.
- hold_cnt width is $clog2(MAX_HOLD+1), with a minimum of 1.
- X/illegal inputs are not handled. req is assumed synchronous to clk.

Decomposition:
- Package arb_pkg:
  - NUM_REQ_C=4, ID_W=2.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - typedef logic [ID_W-1:0] req_id_t.
- Sub-module rr_prio_enc (combinational):
  - Inputs req[3:0], last_ptr[1:0], rr_mode.
  - Outputs win_id[1:0], win_valid.
  - Rotates req by last_ptr+1, priority-encodes, then un-rotates the index.
  - Unit-testable standalone.
- Top holds the FSM, hold counter, pointer and output registers.

Test Plan:
1. Fixed mode, req=4'b1010 held for one cycle after reset -> next cycle grant=4'b1000, grant_id=3, grant_valid=1. The owner drops req[3] -> one cycle later grant=0, then grant=4'b0010, grant_id=1.
2. RR mode, req=4'b1111 held constant, MAX_HOLD=4 -> grant sequence 0,1,2,3,0, each lasting 4 cycles, separated by one idle cycle. timeout pulses once per handover.
3. RR mode, owner id=2 pulses release_i in its 2nd grant cycle with req=4'b0101 -> grant ends after 2 cycles with timeout=0. The next grant goes to id 0, not id 2, after the idle cycle.
4. MAX_HOLD=4, release_i asserted in the same cycle hold_cnt==3 -> grant ends and timeout stays 0.
5. Assert rst_n=0 mid-GRANT between clock edges -> grant, grant_id, grant_valid and timeout are 0 immediately. After release with req=4'b0001, the grant goes to id 0 and the RR pointer has restarted.
6. MAX_HOLD=0, single requester id=1 holding req for 100 cycles -> grant held for all 100 cycles, timeout never asserted, hold_cnt saturates without wrapping.
